ub_input_reader: RTL and testbench
==================================

Name: ub_input_reader

Overview:
- Read-side client of the unified buffer.
- On a start command it issues a one-cycle load request to the unified buffer at a given address, then captures the returned 2x2 activation tile (four words).
- It streams the tile into the two rows of the 2x2 systolic array with diagonal skew: row 1 lags row 0 by one beat.
- It sits between the controller/instruction decoder, the unified buffer read port, and the systolic array's left-edge activation inputs.

Parameters:
- DATA_W, 32, width of one unified-buffer word and of each activation output.
- ADDR_W, 13, width of the unified-buffer address bus.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command: fetch and stream the tile at base_addr.
- base_addr  in  ADDR_W  unified-buffer address of word a00; sampled with start.
- array_stall  in  1  systolic array cannot accept a beat this cycle.
- ub_addr  out  ADDR_W  address to the unified buffer.
- ub_load_input  out  1  load request to the unified buffer.
- ub_out_00, ub_out_01, ub_out_10, ub_out_11  in  DATA_W  tile words a00, a01, a10, a11 returned by the unified buffer.
- act_row0, act_row1  out  DATA_W  activation into array row 0 / row 1.
- act_valid0, act_valid1  out  1  the corresponding act_row carries a real element.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse together with the last beat.

Behaviour:
- Reset (reset low, asynchronous) values:
  - All outputs are 0.
  - The FSM enters IDLE and tile registers clear.
  - Reset mid-operation aborts immediately, drops ub_load_input the same instant, and discards the tile.
- All outputs are registered.
- FSM states: IDLE, REQ, CAPT, STREAM (beat counter 0..2).
- IDLE:
  - start=1 at edge E0 latches base_addr into ub_addr and moves to REQ.
  - busy=1 and ub_load_input=1 after E0.
- REQ:
  - Exactly one cycle; the unified buffer samples the request at E1.
  - After E1: ub_load_input=0, state CAPT.
  - ub_addr holds its value until the next start.
- CAPT:
  - ub_out_* are valid during this cycle (the unified buffer has one-cycle read latency).
  - At E2 all four words are captured into tile registers and state becomes STREAM, beat 0.
  - Beat 0 is driven onto the outputs directly from ub_out_*.
- STREAM beats, each visible for one cycle when not stalled:
  - beat0: act_row0=a00, act_valid0=1; act_row1=0, act_valid1=0.
  - beat1: act_row0=a01, act_valid0=1; act_row1=a10, act_valid1=1.
  - beat2: act_row0=0, act_valid0=0; act_row1=a11, act_valid1=1; done=1.
- After beat2 is accepted, the next edge clears the act_* outputs, done and busy, and returns to IDLE.
- Total cycle count:
  - Start-edge to first beat: 2 edges (E0 to E2).
  - Fetch-and-stream: 5 edges with no stall.
  - An immediate new start is possible at the edge after busy falls.
- array_stall:
  - Sampled only in STREAM. When it is high at an edge, the outputs, including done, hold their current values and the beat counter does not advance.
  - Ignored in REQ/CAPT, because unified-buffer latency is fixed and the tile must be captured at E2.
  - If stalled on beat2, done stays high across the stall; verification treats done as "done && !array_stall".
- start while busy=1 is ignored: it is not queued, and base_addr is not re-latched.
- Data is passed unmodified with no arithmetic.
- base_addr is not range-checked; address wrap and overrun are the unified buffer's responsibility.

Decomposition:
- Shared package tpu_pkg:
  - DATA_W and ADDR_W defaults.
  - The enumerated state type (IDLE, REQ, CAPT, STREAM).
  - Beat-count constant NUM_BEATS = 3.
- One sub-module, ub_skew_feeder: holds the tile registers and beat counter and produces act_row*/act_valid*/done from (load_tile, advance).
- The top level holds the FSM and the unified-buffer request logic.

Test Plan:
- Basic fetch:
  - Stimulus: preload the unified buffer with 11, 12, 21, 22 at 0x1E..0x21; start with base_addr=0x1E.
  - Response: ub_load_input high for exactly 1 cycle with ub_addr=0x1E.
  - Then consecutive beats (11,–), (12,21), (–,22) with the stated valid patterns, done on the third beat, busy low one cycle later.
- Stall:
  - Stimulus: same tile; array_stall=1 for 2 cycles during beat1.
  - Response: (12,21) held for 3 cycles, then beat2; the count of valid-high cycles per row, excluding stalled repeats, is still 2.
- Start while busy:
  - Stimulus: a second start with base_addr=0x00 during STREAM.
  - Response: ignored; ub_load_input never re-asserts; ub_addr stays 0x1E.
- Back-to-back:
  - Stimulus: start at 0x1E, then start at 0x00 the first cycle busy=0, where the unified buffer holds 1, 2, 3, 4.
  - Response: second stream (1,–), (2,3), (–,4).
- Reset mid-operation:
  - Stimulus: reset low during beat1.
  - Response: all outputs 0 immediately, state IDLE; a subsequent start streams correctly.
- Reset mid-REQ:
  - Stimulus: reset low asynchronously while ub_load_input=1.
  - Response: ub_load_input falls without waiting for a clock edge.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the unified-buffer read path feeding the 2x2 systolic array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default bus widths, FSM state encodings, beat count of one skewed tile,
// and a small helper that identifies the final beat.
package tpu_pkg;

   localparam int TPU_DATA_W = 32;
   localparam int TPU_ADDR_W = 13;

   // Reader FSM states, kept as plain constants for legacy tool compatibility.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_REQ    = 2'd1;
   localparam state_t ST_CAPT   = 2'd2;
   localparam state_t ST_STREAM = 2'd3;

   // A 2x2 tile fed with one beat of diagonal skew occupies three beats.
   localparam int          NUM_BEATS = 3;
   localparam logic [1:0]  LAST_BEAT = 2'(NUM_BEATS - 1);

   function automatic logic is_last_beat(input logic [1:0] beat);
      return beat == LAST_BEAT;
   endfunction

endpackage

// File: rtl/ub_skew_feeder.sv
// Holds a captured 2x2 tile and plays it into the array's two rows with a one-beat skew.
// Latency: beat0 registered on the edge that captures the tile; one beat per accepted edge.
// Backpressure: beats and done hold while i_advance is low; nothing moves without it.
//
// Ports:
//   clk, reset             clock, async active-low reset
//   i_load_tile            capture i_ub_out_* and present beat0 on the same edge
//   i_advance              move to the next beat (after the last beat: clear outputs)
//   i_ub_out_00..11        tile words a00, a01, a10, a11
//   o_act_row0/1, o_act_valid0/1, o_done   registered beat outputs
//   o_last_beat            the beat currently presented is the final one
module ub_skew_feeder
   import tpu_pkg::*;
#(
   parameter int DATA_W = TPU_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load_tile,
   input  logic              i_advance,
   input  logic [DATA_W-1:0] i_ub_out_00,
   input  logic [DATA_W-1:0] i_ub_out_01,
   input  logic [DATA_W-1:0] i_ub_out_10,
   input  logic [DATA_W-1:0] i_ub_out_11,
   output logic [DATA_W-1:0] o_act_row0,
   output logic [DATA_W-1:0] o_act_row1,
   output logic              o_act_valid0,
   output logic              o_act_valid1,
   output logic              o_done,
   output logic              o_last_beat
);

   logic [DATA_W-1:0] r_a00, r_a01, r_a10, r_a11;
   logic [1:0]        r_beat;
   logic [DATA_W-1:0] r_act_row0, r_act_row1;
   logic              r_act_valid0, r_act_valid1, r_done;

   logic [1:0]        w_sel;
   logic [DATA_W-1:0] w_a00, w_a01, w_a10, w_a11;
   logic [DATA_W-1:0] w_row0, w_row1;
   logic              w_v0, w_v1, w_done;

   // Pick the beat to present next and where its words come from. Beat0 is taken
   // straight from the buffer outputs because the tile registers fill on that same edge.
   // Advancing past the last beat selects index 3, which decodes to all-zero outputs.
   always_comb begin
      w_sel = r_beat + 2'd1;
      w_a00 = r_a00;
      w_a01 = r_a01;
      w_a10 = r_a10;
      w_a11 = r_a11;
      if (i_load_tile) begin
         w_sel = 2'd0;
         w_a00 = i_ub_out_00;
         w_a01 = i_ub_out_01;
         w_a10 = i_ub_out_10;
         w_a11 = i_ub_out_11;
      end

      w_row0 = '0;
      w_row1 = '0;
      w_v0   = 1'b0;
      w_v1   = 1'b0;
      w_done = 1'b0;
      case (w_sel)
         2'd0: begin
            w_row0 = w_a00;
            w_v0   = 1'b1;
         end
         2'd1: begin
            w_row0 = w_a01;
            w_v0   = 1'b1;
            w_row1 = w_a10;
            w_v1   = 1'b1;
         end
         2'd2: begin
            w_row1 = w_a11;
            w_v1   = 1'b1;
            w_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a00        <= '0;
         r_a01        <= '0;
         r_a10        <= '0;
         r_a11        <= '0;
         r_beat       <= 2'd0;
         r_act_row0   <= '0;
         r_act_row1   <= '0;
         r_act_valid0 <= 1'b0;
         r_act_valid1 <= 1'b0;
         r_done       <= 1'b0;
      end else if (i_load_tile || i_advance) begin
         if (i_load_tile) begin
            r_a00 <= i_ub_out_00;
            r_a01 <= i_ub_out_01;
            r_a10 <= i_ub_out_10;
            r_a11 <= i_ub_out_11;
         end
         r_beat       <= (w_sel > LAST_BEAT) ? 2'd0 : w_sel;
         r_act_row0   <= w_row0;
         r_act_row1   <= w_row1;
         r_act_valid0 <= w_v0;
         r_act_valid1 <= w_v1;
         r_done       <= w_done;
      end
   end

   assign o_act_row0   = r_act_row0;
   assign o_act_row1   = r_act_row1;
   assign o_act_valid0 = r_act_valid0;
   assign o_act_valid1 = r_act_valid1;
   assign o_done       = r_done;
   assign o_last_beat  = is_last_beat(r_beat);

endmodule

// File: rtl/ub_input_reader.sv
// Fetches one 2x2 activation tile from the unified buffer and streams it, skewed, into the array.
// Latency: start edge to first beat 2 edges; full fetch-and-stream 5 edges without stalls.
// Backpressure: array_stall freezes the stream (done included); request/capture cannot stall.
//
// Ports:
//   clk, reset                  clock, async active-low reset (aborts any operation)
//   start, base_addr            one-cycle command and tile address (ignored while busy)
//   array_stall                 array refuses the current beat
//   ub_addr, ub_load_input      read request to the unified buffer
//   ub_out_00..11               tile words returned one cycle after the request
//   act_row0/1, act_valid0/1    left-edge activations into array rows 0/1
//   busy, done                  operation in flight / last beat marker
module ub_input_reader
   import tpu_pkg::*;
#(
   parameter int DATA_W = TPU_DATA_W,
   parameter int ADDR_W = TPU_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              array_stall,
   output logic [ADDR_W-1:0] ub_addr,
   output logic              ub_load_input,
   input  logic [DATA_W-1:0] ub_out_00,
   input  logic [DATA_W-1:0] ub_out_01,
   input  logic [DATA_W-1:0] ub_out_10,
   input  logic [DATA_W-1:0] ub_out_11,
   output logic [DATA_W-1:0] act_row0,
   output logic [DATA_W-1:0] act_row1,
   output logic              act_valid0,
   output logic              act_valid1,
   output logic              busy,
   output logic              done
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ub_addr;
   logic              r_ub_load;
   logic              r_busy;

   logic              w_load_tile;
   logic              w_advance;
   logic              w_last_beat;

   // The buffer's read latency is fixed, so the capture edge is never stalled.
   assign w_load_tile = (r_state == ST_CAPT);
   assign w_advance   = (r_state == ST_STREAM) && !array_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_ub_addr <= '0;
         r_ub_load <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ub_addr <= base_addr;
                  r_ub_load <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_ub_load <= 1'b0;
               r_state   <= ST_CAPT;
            end
            ST_CAPT: begin
               r_state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (w_advance && w_last_beat) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_ub_load <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   ub_skew_feeder #(
      .DATA_W (DATA_W)
   ) u_feeder (
      .clk          (clk),
      .reset        (reset),
      .i_load_tile  (w_load_tile),
      .i_advance    (w_advance),
      .i_ub_out_00  (ub_out_00),
      .i_ub_out_01  (ub_out_01),
      .i_ub_out_10  (ub_out_10),
      .i_ub_out_11  (ub_out_11),
      .o_act_row0   (act_row0),
      .o_act_row1   (act_row1),
      .o_act_valid0 (act_valid0),
      .o_act_valid1 (act_valid1),
      .o_done       (done),
      .o_last_beat  (w_last_beat)
   );

   assign ub_addr       = r_ub_addr;
   assign ub_load_input = r_ub_load;
   assign busy          = r_busy;

endmodule

// File: tb/tb_ub_input_reader.sv
// Self-checking bench for ub_input_reader: a unified-buffer model answers load requests,
// the stimulus pushes expected beats into a scoreboard, and a monitor pops and compares
// every beat the array accepts.
module tb_ub_input_reader;

   localparam int DW = 32;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          array_stall;
   logic [AW-1:0] ub_addr;
   logic          ub_load_input;
   logic [DW-1:0] ub_out_00, ub_out_01, ub_out_10, ub_out_11;
   logic [DW-1:0] act_row0, act_row1;
   logic          act_valid0, act_valid1, busy, done;

   int total = 0;
   int bad   = 0;
   int load_cnt = 0;
   int v0_cnt = 0;
   int v1_cnt = 0;

   typedef struct packed {
      logic [DW-1:0] r0;
      logic          v0;
      logic [DW-1:0] r1;
      logic          v1;
      logic          dn;
   } beat_t;

   beat_t sb_q[$];

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   ub_input_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .array_stall   (array_stall),
      .ub_addr       (ub_addr),
      .ub_load_input (ub_load_input),
      .ub_out_00     (ub_out_00),
      .ub_out_01     (ub_out_01),
      .ub_out_10     (ub_out_10),
      .ub_out_11     (ub_out_11),
      .act_row0      (act_row0),
      .act_row1      (act_row1),
      .act_valid0    (act_valid0),
      .act_valid1    (act_valid1),
      .busy          (busy),
      .done          (done)
   );

   // Unified buffer: one-cycle read latency, words a00,a01,a10,a11 at addr..addr+3.
   initial begin
      ub_out_00 = '0;
      ub_out_01 = '0;
      ub_out_10 = '0;
      ub_out_11 = '0;
   end
   always @(posedge clk) begin
      if (ub_load_input) begin
         ub_out_00 <= mem[ub_addr];
         ub_out_01 <= mem[ub_addr + 13'd1];
         ub_out_10 <= mem[ub_addr + 13'd2];
         ub_out_11 <= mem[ub_addr + 13'd3];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected skewed stream for tile (a00,a01;a10,a11).
   task automatic push_tile(input logic [DW-1:0] a00, input logic [DW-1:0] a01,
                            input logic [DW-1:0] a10, input logic [DW-1:0] a11);
      sb_q.push_back('{r0: a00, v0: 1'b1, r1: '0,  v1: 1'b0, dn: 1'b0});
      sb_q.push_back('{r0: a01, v0: 1'b1, r1: a10, v1: 1'b1, dn: 1'b0});
      sb_q.push_back('{r0: '0,  v0: 1'b0, r1: a11, v1: 1'b1, dn: 1'b1});
   endtask

   // Monitor: a beat counts only when presented and not stalled at the coming edge.
   always @(negedge clk) begin
      beat_t e;
      if (ub_load_input) load_cnt++;
      if (reset && (act_valid0 || act_valid1) && !array_stall) begin
         if (act_valid0) v0_cnt++;
         if (act_valid1) v1_cnt++;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got row0=%0d row1=%0d expected no beat", act_row0, act_row1);
         end else begin
            e = sb_q.pop_front();
            check("beat_row0",   64'(act_row0),   64'(e.r0));
            check("beat_valid0", 64'(act_valid0), 64'(e.v0));
            check("beat_row1",   64'(act_row1),   64'(e.r1));
            check("beat_valid1", 64'(act_valid1), 64'(e.v1));
            check("beat_done",   64'(done),       64'(e.dn));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] addr);
      start     = 1'b1;
      base_addr = addr;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

   initial begin
      int ld0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[13'h1E] = 32'd11;
      mem[13'h1F] = 32'd12;
      mem[13'h20] = 32'd21;
      mem[13'h21] = 32'd22;
      mem[13'h00] = 32'd1;
      mem[13'h01] = 32'd2;
      mem[13'h02] = 32'd3;
      mem[13'h03] = 32'd4;

      reset       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      array_stall = 1'b0;
      #3;
      check("rst_load",   64'(ub_load_input), 64'd0);
      check("rst_busy",   64'(busy),          64'd0);
      check("rst_valid0", 64'(act_valid0),    64'd0);
      check("rst_valid1", 64'(act_valid1),    64'd0);
      check("rst_done",   64'(done),          64'd0);
      check("rst_addr",   64'(ub_addr),       64'd0);
      #9 reset = 1'b1;
      tick();

      // Basic fetch at 0x1E.
      ld0 = load_cnt;
      push_tile(32'd11, 32'd12, 32'd21, 32'd22);
      issue(13'h1E);
      check("basic_load_hi",  64'(ub_load_input), 64'd1);
      check("basic_addr",     64'(ub_addr),       64'h1E);
      check("basic_busy",     64'(busy),          64'd1);
      tick();
      check("basic_load_lo",  64'(ub_load_input), 64'd0);
      check("basic_capt_v0",  64'(act_valid0),    64'd0);
      tick();
      tick();
      tick();
      check("basic_done",     64'(done),          64'd1);
      check("basic_busy_b2",  64'(busy),          64'd1);
      tick();
      check("basic_busy_lo",  64'(busy),          64'd0);
      check("basic_done_lo",  64'(done),          64'd0);
      check("basic_clr_v1",   64'(act_valid1),    64'd0);
      check("basic_load_cnt", 64'(load_cnt - ld0), 64'd1);
      check("basic_sb_empty", 64'(sb_q.size()),   64'd0);
      tick();

      // Stall two edges during beat1.
      v0_cnt = 0;
      v1_cnt = 0;
      push_tile(32'd11, 32'd12, 32'd21, 32'd22);
      issue(13'h1E);
      tick();
      tick();
      tick();
      array_stall = 1'b1;
      tick();
      check("stall_hold_r0",  64'(act_row0),   64'd12);
      check("stall_hold_r1",  64'(act_row1),   64'd21);
      tick();
      check("stall_hold2_r0", 64'(act_row0),   64'd12);
      check("stall_hold2_v1", 64'(act_valid1), 64'd1);
      check("stall_hold_dn",  64'(done),       64'd0);
      array_stall = 1'b0;
      tick();
      check("stall_b2_r1",    64'(act_row1),   64'd22);
      check("stall_b2_done",  64'(done),       64'd1);
      tick();
      check("stall_busy_lo",  64'(busy),       64'd0);
      check("stall_v0_cnt",   64'(v0_cnt),     64'd2);
      check("stall_v1_cnt",   64'(v1_cnt),     64'd2);
      tick();

      // Start while busy is ignored; stall on beat2 keeps done high.
      ld0 = load_cnt;
      push_tile(32'd11, 32'd12, 32'd21, 32'd22);
      issue(13'h1E);
      tick();
      tick();
      start     = 1'b1;
      base_addr = 13'h00;
      tick();
      start = 1'b0;
      check("busy_start_addr", 64'(ub_addr),  64'h1E);
      check("busy_start_busy", 64'(busy),     64'd1);
      tick();
      array_stall = 1'b1;
      tick();
      check("b2stall_done",    64'(done),     64'd1);
      check("b2stall_r1",      64'(act_row1), 64'd22);
      array_stall = 1'b0;
      tick();
      check("b2stall_busy_lo", 64'(busy),     64'd0);
      check("busy_start_addr2", 64'(ub_addr), 64'h1E);
      tick();
      tick();
      check("busy_start_idle", 64'(busy),     64'd0);
      check("busy_start_loads", 64'(load_cnt - ld0), 64'd1);
      check("busy_sb_empty",   64'(sb_q.size()), 64'd0);

      // Back-to-back: second start on the first cycle busy is low.
      ld0 = load_cnt;
      push_tile(32'd11, 32'd12, 32'd21, 32'd22);
      push_tile(32'd1, 32'd2, 32'd3, 32'd4);
      issue(13'h1E);
      tick();
      tick();
      tick();
      tick();
      tick();
      check("b2b_busy_gap", 64'(busy), 64'd0);
      issue(13'h00);
      check("b2b_addr2",    64'(ub_addr), 64'h00);
      check("b2b_load2",    64'(ub_load_input), 64'd1);
      tick();
      tick();
      tick();
      tick();
      tick();
      check("b2b_idle",     64'(busy), 64'd0);
      check("b2b_loads",    64'(load_cnt - ld0), 64'd2);
      check("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset during beat1, then a clean operation.
      push_tile(32'd11, 32'd12, 32'd21, 32'd22);
      issue(13'h1E);
      tick();
      tick();
      tick();
      check("mid_pre_r0", 64'(act_row0), 64'd12);
      reset = 1'b0;
      #1;
      check("mid_rst_v0",   64'(act_valid0), 64'd0);
      check("mid_rst_v1",   64'(act_valid1), 64'd0);
      check("mid_rst_r0",   64'(act_row0),   64'd0);
      check("mid_rst_r1",   64'(act_row1),   64'd0);
      check("mid_rst_busy", 64'(busy),       64'd0);
      check("mid_rst_addr", 64'(ub_addr),    64'd0);
      sb_q.delete();
      #1 reset = 1'b1;
      tick();
      push_tile(32'd1, 32'd2, 32'd3, 32'd4);
      issue(13'h00);
      check("post_rst_load", 64'(ub_load_input), 64'd1);
      tick();
      tick();
      tick();
      tick();
      tick();
      check("post_rst_idle", 64'(busy), 64'd0);
      check("post_rst_sb",   64'(sb_q.size()), 64'd0);

      // Reset while the request is on the bus: it drops without a clock edge.
      issue(13'h1E);
      check("req_load_hi", 64'(ub_load_input), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("req_load_async", 64'(ub_load_input), 64'd0);
      check("req_busy_async", 64'(busy),          64'd0);
      #1 reset = 1'b1;
      tick();
      tick();
      tick();
      check("req_no_stream", 64'(act_valid0), 64'd0);

      check("final_sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
